coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 181 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced coin detector, coin FIFO and timed en_* pulse generator
// for the downstream vending controller.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 2,
  parameter int GAP      = 4,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   coin_in,
  input  logic [1:0]             coin_type,
  input  logic                   accept_en,
  input  logic                   flush,
  output logic                   en_one,
  output logic                   en_two,
  output logic                   en_five,
  output logic                   coin_reject,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count
);

  // state  | meaning
  // S_IDLE | no pulse active; pops the queue head as soon as it is non-empty
  // S_HOLD | selected en_* high; timer counts down the HOLD cycles
  // S_GAP  | all en_* low; timer counts down GAP cycles, terminal count may pop directly

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [1:0]      sel, sel_nxt;

  logic            armed, armed_nxt;
  logic [DW-1:0]   db_cnt, cnt_nxt, run;
  logic [1:0]      last_type, last_nxt;
  logic            det_event;

  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop, reject_nxt;
  logic [CW-1:0]   count_nxt;

  // Armed: count identical coin-present samples; disarmed: count coin-absent samples.
  always_comb begin
    det_event = 1'b0;
    armed_nxt = armed;
    cnt_nxt   = db_cnt;
    last_nxt  = last_type;
    run       = '0;
    if (armed) begin
      if (coin_in) begin
        run      = (db_cnt != '0 && coin_type == last_type) ? db_cnt + 1'b1 : DW'(1);
        last_nxt = coin_type;
        if (run == DW'(DEBOUNCE)) begin
          det_event = 1'b1;
          armed_nxt = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = run;
        end
      end else begin
        cnt_nxt = '0;
      end
    end else begin
      if (!coin_in) begin
        run = db_cnt + 1'b1;
        if (run == DW'(DEBOUNCE)) begin
          armed_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = run;
        end
      end else begin
        cnt_nxt = '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    sel_nxt   = sel;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = S_HOLD;
          timer_nxt = TW'(HOLD - 1);
          sel_nxt   = mem[rptr];
        end
      end
      S_HOLD: begin
        if (timer == '0) begin
          state_nxt = S_GAP;
          timer_nxt = TW'(GAP - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_GAP: begin
        // Popping on the last gap cycle keeps the low time between pulses at exactly GAP.
        if (timer == '0) begin
          if (fifo_count != '0) begin
            pop       = 1'b1;
            state_nxt = S_HOLD;
            timer_nxt = TW'(HOLD - 1);
            sel_nxt   = mem[rptr];
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
      pop       = 1'b0;
    end
  end

  always_comb begin
    push       = det_event && (coin_type != 2'b00) && accept_en && (!fifo_full || pop) && !flush;
    reject_nxt = det_event && !push && !flush;
    count_nxt  = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      sel         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fifo_count  <= '0;
      fifo_full   <= 1'b0;
      coin_reject <= 1'b0;
      armed       <= 1'b1;
      db_cnt      <= '0;
      last_type   <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      sel         <= sel_nxt;
      fifo_count  <= count_nxt;
      fifo_full   <= (count_nxt == CW'(DEPTH));
      coin_reject <= reject_nxt;
      if (flush) begin
        wptr   <= '0;
        rptr   <= '0;
        armed  <= 1'b1;
        db_cnt <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        armed     <= armed_nxt;
        db_cnt    <= cnt_nxt;
        last_type <= last_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= coin_type;
  end

  assign en_one  = (state == S_HOLD) && (sel == 2'b01);
  assign en_two  = (state == S_HOLD) && (sel == 2'b10);
  assign en_five = (state == S_HOLD) && (sel == 2'b11);

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized bench for coin_acceptor: two instances (default timing and a slow,
// queue-filling variant) checked every cycle against a timeline-based model.
module tb_coin_acceptor;

  localparam int N = 2;

  function automatic int p_deb(int i);   return (i == 0) ? 4 : 2; endfunction
  function automatic int p_hold(int i);  return (i == 0) ? 2 : 5; endfunction
  function automatic int p_gap(int i);   return (i == 0) ? 4 : 6; endfunction
  function automatic int p_depth(int i); return 4; endfunction

  logic       clk = 1'b0;
  logic       rst, coin_in, accept_en, flush;
  logic [1:0] coin_type;

  logic       u0_one, u0_two, u0_five, u0_rej, u0_full;
  logic [2:0] u0_cnt;
  logic       u1_one, u1_two, u1_five, u1_rej, u1_full;
  logic [2:0] u1_cnt;

  coin_acceptor #(.DEBOUNCE(4), .HOLD(2), .GAP(4), .DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .coin_in(coin_in), .coin_type(coin_type),
    .accept_en(accept_en), .flush(flush),
    .en_one(u0_one), .en_two(u0_two), .en_five(u0_five),
    .coin_reject(u0_rej), .fifo_full(u0_full), .fifo_count(u0_cnt));

  coin_acceptor #(.DEBOUNCE(2), .HOLD(5), .GAP(6), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .coin_in(coin_in), .coin_type(coin_type),
    .accept_en(accept_en), .flush(flush),
    .en_one(u1_one), .en_two(u1_two), .en_five(u1_five),
    .coin_reject(u1_rej), .fifo_full(u1_full), .fifo_count(u1_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: streak counters for the detector, a plain queue of coins, and the
  // pulse timeline (start edge of the current pulse, earliest edge of the next).
  int one_s[N], zero_s[N], last_s[N], free_at[N], p_start[N], p_type[N], exp_rej[N];
  bit armed_m[N];
  int q0[$];
  int q1[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int q_size(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int q_pop(int i);
    int v;
    if (i == 0) v = q0.pop_front(); else v = q1.pop_front();
    return v;
  endfunction

  function automatic void q_push(int i, int v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic void model_reset(int i);
    if (i == 0) q0.delete(); else q1.delete();
    one_s[i] = 0; zero_s[i] = 0; last_s[i] = 0; armed_m[i] = 1'b1;
    free_at[i] = 0; p_start[i] = -1000; p_type[i] = 0; exp_rej[i] = 0;
  endfunction

  function automatic void model_edge(int i, int e);
    bit ev, pop, push;
    int ct;
    ct = int'(coin_type);
    ev = 1'b0;
    if (flush) begin
      if (i == 0) q0.delete(); else q1.delete();
      one_s[i] = 0; zero_s[i] = 0; armed_m[i] = 1'b1;
      p_start[i] = -1000; free_at[i] = e + 1; exp_rej[i] = 0;
      return;
    end
    if (coin_in) begin
      one_s[i] = (one_s[i] > 0 && ct == last_s[i]) ? one_s[i] + 1 : 1;
      last_s[i] = ct;
      zero_s[i] = 0;
    end else begin
      one_s[i] = 0;
      zero_s[i]++;
    end
    if (armed_m[i] && one_s[i] == p_deb(i)) begin
      ev = 1'b1;
      armed_m[i] = 1'b0;
    end else if (!armed_m[i] && zero_s[i] == p_deb(i)) begin
      armed_m[i] = 1'b1;
    end
    pop  = (q_size(i) > 0) && (e >= free_at[i]);
    push = ev && ct != 0 && accept_en && (q_size(i) < p_depth(i) || pop);
    if (pop) begin
      p_type[i]  = q_pop(i);
      p_start[i] = e;
      free_at[i] = e + p_hold(i) + p_gap(i);
    end
    if (push) q_push(i, ct);
    exp_rej[i] = (ev && !push) ? 1 : 0;
  endfunction

  function automatic int exp_en(int i);
    int e;
    e = edge_n - 1;
    if (p_start[i] <= e && (e - p_start[i]) < p_hold(i))
      return (p_type[i] == 1) ? 1 : (p_type[i] == 2) ? 2 : (p_type[i] == 3) ? 4 : 0;
    return 0;
  endfunction

  task automatic check_all();
    chk("u0.en",   int'({u0_five, u0_two, u0_one}), exp_en(0));
    chk("u0.rej",  int'(u0_rej),  exp_rej[0]);
    chk("u0.cnt",  int'(u0_cnt),  q_size(0));
    chk("u0.full", int'(u0_full), (q_size(0) == p_depth(0)) ? 1 : 0);
    chk("u1.en",   int'({u1_five, u1_two, u1_one}), exp_en(1));
    chk("u1.rej",  int'(u1_rej),  exp_rej[1]);
    chk("u1.cnt",  int'(u1_cnt),  q_size(1));
    chk("u1.full", int'(u1_full), (q_size(1) == p_depth(1)) ? 1 : 0);
  endtask

  task automatic step(input bit ci, input int ct, input bit acc, input bit fl);
    coin_in   = ci;
    coin_type = 2'(ct);
    accept_en = acc;
    flush     = fl;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst) model_reset(i);
      else      model_edge(i, edge_n);
    end
    edge_n++;
    #1;
    check_all();
  endtask

  task automatic coin(input int ct, input int on_c, input int off_c, input bit acc);
    for (int k = 0; k < on_c; k++)  step(1'b1, ct, acc, 1'b0);
    for (int k = 0; k < off_c; k++) step(1'b0, ct, acc, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; coin_in = 1'b0; coin_type = 2'b00; accept_en = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++) model_reset(i);
    #1;
    check_all();
    idle(2);
    rst = 1'b1;

    // Single two-coin held for 6 cycles; then 2-on/2-off toggling.
    coin(2, 6, 6, 1'b1);
    idle(6);
    for (int k = 0; k < 6; k++) coin(1, 2, 2, 1'b1);
    idle(40);

    // Invalid code, then a five with acceptance disabled.
    coin(0, 4, 4, 1'b1);
    coin(3, 4, 4, 1'b0);
    idle(4);

    // Burst of five coins, drained in order.
    coin(1, 4, 4, 1'b1);
    coin(2, 4, 4, 1'b1);
    coin(3, 4, 4, 1'b1);
    coin(1, 4, 4, 1'b1);
    coin(3, 4, 4, 1'b1);
    idle(60);

    // Several queued coins, then flush mid-pulse.
    coin(3, 4, 4, 1'b1);
    coin(1, 4, 4, 1'b1);
    coin(2, 4, 1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    idle(10);

    // Asynchronous reset in the middle of a five pulse.
    coin(3, 4, 0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("pre_rst.en_five", int'(u0_five), 1);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) model_reset(i);
    chk("rst.en0", int'({u0_five, u0_two, u0_one}), 0);
    chk("rst.cnt0", int'(u0_cnt), 0);
    chk("rst.en1", int'({u1_five, u1_two, u1_one}), 0);
    check_all();
    idle(2);
    rst = 1'b1;
    coin(1, 4, 6, 1'b1);
    idle(20);

    for (int s = 0; s < 250; s++) begin
      int kind, t, t2;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        t = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
        coin(t, $urandom_range(1, 7), $urandom_range(1, 6), $urandom_range(0, 5) != 0);
      end else if (kind == 6) begin
        for (int k = 0; k < $urandom_range(2, 4); k++) coin(1, 2, 2, 1'b1);
      end else if (kind == 7) begin
        t  = $urandom_range(1, 3);
        t2 = $urandom_range(0, 3);
        for (int k = 0; k < $urandom_range(1, 5); k++) step(1'b1, t, 1'b1, 1'b0);
        coin(t2, $urandom_range(1, 6), $urandom_range(1, 5), 1'b1);
      end else if (kind == 8) begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 3), 1'b1, 1'b1);
      end else begin
        idle($urandom_range(5, 25));
      end
    end
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
